spi_ram_master_ctrl: RTL and testbench
======================================

// Module: spi_ram_master_ctrl
// PURPOSE
//  Host-side transaction sequencer for the single-clock SPI RAM slave path.
//  Accepts one-shot host write/read commands and expands each into two serial frames on ss_n/mosi:
//  address, then data.
//  For reads it captures the 8-bit MISO reply and returns it on a valid pulse.
//  Sits between a host/register bus and the SPI slave + RAM pair; shares the slave's clk (no SCLK).
// PARAMETERS
//  RD_LAT   3  cycles SS_n stays low after the last bit of a read-data frame before MISO bit 7 is sampled
//  GAP_CYC  2  cycles ss_n is held high between frames and after the final frame (min 1)
// PORTS
//  clk        in   1  clock; all logic on rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  cmd_valid  in   1  host command present
//  cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1  1 = RAM write, 0 = RAM read
//  cmd_addr   in   8  RAM address
//  cmd_wdata  in   8  write data (ignored for reads)
//  ss_n       out  1  slave select to SPI slave, active-low
//  mosi       out  1  serial data to slave
//  miso       in   1  serial data from slave
//  rd_data    out  8  captured read data; holds until the next read completes
//  rd_valid   out  1  one-cycle pulse, rd_data valid
//  busy       out  1  high from the cycle after acceptance until the return to IDLE
// BEHAVIOUR
//  Reset (async): ss_n=1, mosi=0, rd_data=0, rd_valid=0, busy=0, cmd_ready=1, state=IDLE, counters=0.
//    Reset mid-frame aborts immediately and drives ss_n high; the partial frame is dropped.
//  All outputs are registered. The command fields are latched on acceptance; later changes are ignored.
//  Frame word W[9:0] = {op[1:0], payload[7:0]}:
//    op 00 = write addr, 01 = write data, 10 = read addr, 11 = read data.
//  Command expansion:
//    write = frame {00,addr}, then frame {01,wdata}.
//    read  = frame {10,addr}, then frame {11,8'h00}, then capture.
//  FSM states: IDLE -> SEL -> ROUTE -> SHIFT -> [WAIT -> CAPTURE] -> GAP -> (SEL of 2nd frame | IDLE).
//    SEL: ss_n=0, mosi=0; 1 cycle.
//    ROUTE: ss_n=0, mosi=W[9] (route bit: 0 write path, 1 read path); 1 cycle.
//    SHIFT: ss_n=0, mosi=W[9]..W[0] MSB first; 10 cycles; 4-bit counter.
//      Total low time for a non-capture frame = 12 cycles.
//    WAIT: only after a {11,..} frame. ss_n=0, mosi=0, RD_LAT cycles.
//    CAPTURE: ss_n=0; sample miso on 8 consecutive edges into shift reg, bit 7 first.
//      After the 8th sample: rd_data <= shift reg and rd_valid=1 for exactly 1 cycle, coincident with entry to GAP.
//    GAP: ss_n=1, mosi=0, GAP_CYC cycles.
//      Leaves to SEL if the second frame is pending, else to IDLE (busy=0, cmd_ready=1).
//  Back-to-back: a command presented in IDLE is accepted that cycle; SEL follows on the next cycle.
//  No command queueing; cmd_valid while busy is stalled (cmd_ready=0), never dropped or overwritten.
//  Counters saturate at their terminal count and clear on state entry; no wrap.
//  A write occupies 2*(12+GAP_CYC) cycles from SEL to IDLE.
//  A read occupies 2*(12+GAP_CYC)+RD_LAT+8 cycles.
// STRUCTURE
//  spi_ram_pkg (shared):
//    localparams OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
//    FRAME_BITS=10, DATA_BITS=8
//    state encoding constants
//    The slave side uses the same op constants.
//  Sub-module spi_ram_frame_tx: one-frame serializer + optional capture (SEL..CAPTURE, start/done handshake).
//  The top level keeps the command latch, frame sequencing and GAP timing.
// TESTING
//  Reset, then write addr=0x3C data=0xA5:
//    frame 1: ss_n low 12 cycles; mosi = 0,0,0,0,0,1,1,1,1,0,0 after SEL.
//    frame 2: word 01_1010_0101.
//    busy falls after 2*(12+2) = 28 cycles.
//  Read addr=0x3C with the bench slave model returning 0xB6 on miso after RD_LAT=3:
//    frames {10,3C} then {11,00}.
//    rd_data=0xB6 and rd_valid high exactly 1 cycle.
//  Back-to-back: hold cmd_valid with a write then a read.
//    The second command is accepted only in the IDLE cycle after the first completes.
//    cmd_ready=0 throughout busy; no frame corruption.
//  Reset asserted at SHIFT bit 5 of the first frame:
//    ss_n=1 and mosi=0 asynchronously; all outputs at reset values.
//    After release the next command starts cleanly with SEL.
//  Command fields changed while busy: issued frames still carry the latched values.
//  Sweep GAP_CYC=1 and RD_LAT=0: ss_n high exactly 1 cycle between frames.
//    With RD_LAT=0, miso bit 7 is sampled the cycle after the last SHIFT bit.

Source files
------------

// File: rtl/spi_ram_master_ctrl_pkg.sv
// Shared constants and state encodings for the SPI RAM master sequencer.
// The slave side decodes frames with the same op constants.
package spi_ram_master_ctrl_pkg;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   localparam int FRAME_BITS = 10;
   localparam int DATA_BITS  = 8;

   // Command-level sequencer: idle, one frame in flight, inter-frame gap
   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_FRAME,
      SEQ_GAP
   } seq_state_t;

   // Single-frame serializer phases
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_SEL,
      TX_ROUTE,
      TX_SHIFT,
      TX_WAIT,
      TX_CAPTURE
   } tx_state_t;

   // Frame word layout: op in the top two bits, payload below
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [1:0]           op,
                                                        input logic [DATA_BITS-1:0] payload);
      return {op, payload};
   endfunction

endpackage

// File: rtl/spi_ram_master_ctrl_if.sv
// Host command / read-return bus of the SPI RAM master sequencer.
// master = host side, slave = the sequencer.
interface spi_ram_master_ctrl_if;

   logic                                         cmd_valid;
   logic                                         cmd_ready;
   logic                                         cmd_write;
   logic [spi_ram_master_ctrl_pkg::DATA_BITS-1:0] cmd_addr;
   logic [spi_ram_master_ctrl_pkg::DATA_BITS-1:0] cmd_wdata;
   logic [spi_ram_master_ctrl_pkg::DATA_BITS-1:0] rd_data;
   logic                                         rd_valid;
   logic                                         busy;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready, rd_data, rd_valid, busy
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready, rd_data, rd_valid, busy
   );

endinterface

// File: rtl/spi_ram_master_ctrl_frame_tx.sv
// One-frame serializer: SEL, ROUTE, 10 SHIFT bits, and for read-data frames
// an RD_LAT wait followed by an 8-bit MISO capture. All outputs registered;
// done is a same-cycle strobe on the last cycle of the frame.
module spi_ram_master_ctrl_frame_tx
   import spi_ram_master_ctrl_pkg::*;
#(
   parameter int RD_LAT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] word,
   input  logic                  capture,
   input  logic                  miso,
   output logic                  done,
   output logic                  ss_n,
   output logic                  mosi,
   output logic [DATA_BITS-1:0]  rd_data,
   output logic                  rd_valid
);

   localparam int CNT_W = (RD_LAT > 16) ? $clog2(RD_LAT) : 4;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LAT > 0) ? RD_LAT - 1 : 0);
   localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_BITS - 1);

   tx_state_t             state_reg, state_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next, term;
   logic [FRAME_BITS-1:0] tx_sh_reg, tx_sh_next;
   logic [DATA_BITS-1:0]  rx_sh_reg, rx_sh_next;
   logic [DATA_BITS-1:0]  rd_data_reg, rd_data_next;
   logic                  cap_reg, cap_next;
   logic                  rd_valid_reg, rd_valid_next;
   logic                  ss_n_reg, ss_n_next;
   logic                  mosi_reg, mosi_next;

   // Next state, counter and next-cycle pin values; outputs are computed for the state being entered
   always_comb begin
      state_next    = state_reg;
      done          = 1'b0;
      term          = '0;
      tx_sh_next    = tx_sh_reg;
      rx_sh_next    = rx_sh_reg;
      cap_next      = cap_reg;
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      case (state_reg)
         TX_IDLE: begin
            if (start) begin
               state_next = TX_SEL;
               tx_sh_next = word;
               cap_next   = capture;
            end
         end
         TX_SEL:   state_next = TX_ROUTE;
         TX_ROUTE: state_next = TX_SHIFT;
         TX_SHIFT: begin
            term = SHIFT_LAST;
            if (cnt_reg == SHIFT_LAST) begin
               if (!cap_reg) begin
                  state_next = TX_IDLE;
                  done       = 1'b1;
               end else if (RD_LAT == 0) begin
                  state_next = TX_CAPTURE;
               end else begin
                  state_next = TX_WAIT;
               end
            end else begin
               tx_sh_next = {tx_sh_reg[FRAME_BITS-2:0], 1'b0};
            end
         end
         TX_WAIT: begin
            term = WAIT_LAST;
            if (cnt_reg == WAIT_LAST) state_next = TX_CAPTURE;
         end
         TX_CAPTURE: begin
            term       = CAP_LAST;
            rx_sh_next = {rx_sh_reg[DATA_BITS-2:0], miso};
            if (cnt_reg == CAP_LAST) begin
               state_next    = TX_IDLE;
               done          = 1'b1;
               rd_data_next  = rx_sh_next;
               rd_valid_next = 1'b1;
            end
         end
         default: state_next = TX_IDLE;
      endcase

      // Counter clears on every state entry and holds at the state's terminal count
      if (state_next != state_reg)
         cnt_next = '0;
      else if (cnt_reg == term)
         cnt_next = cnt_reg;
      else
         cnt_next = cnt_reg + CNT_W'(1);

      // Route bit and shift bits both come from the top of the shift register
      ss_n_next = (state_next == TX_IDLE);
      mosi_next = ((state_next == TX_ROUTE) || (state_next == TX_SHIFT)) ?
                  tx_sh_next[FRAME_BITS-1] : 1'b0;
   end

   // State and registered outputs; reset releases the bus immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= TX_IDLE;
         cnt_reg      <= '0;
         tx_sh_reg    <= '0;
         rx_sh_reg    <= '0;
         cap_reg      <= 1'b0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         ss_n_reg     <= 1'b1;
         mosi_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         tx_sh_reg    <= tx_sh_next;
         rx_sh_reg    <= rx_sh_next;
         cap_reg      <= cap_next;
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         ss_n_reg     <= ss_n_next;
         mosi_reg     <= mosi_next;
      end
   end

   assign ss_n     = ss_n_reg;
   assign mosi     = mosi_reg;
   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/spi_ram_master_ctrl.sv
// Host-side SPI RAM transaction sequencer: accepts one command at a time and
// expands it into an address frame and a data frame separated by GAP_CYC idle
// cycles; read replies are returned through the frame serializer's capture.
module spi_ram_master_ctrl
   import spi_ram_master_ctrl_pkg::*;
#(
   parameter int RD_LAT  = 3,
   parameter int GAP_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_ram_master_ctrl_if.slave host,
   output logic                 ss_n,
   output logic                 mosi,
   input  logic                 miso
);

   localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   seq_state_t            state_reg, state_next;
   logic [GAP_W-1:0]      gcnt_reg, gcnt_next;
   logic                  write_reg, write_next;
   logic [DATA_BITS-1:0]  wdata_reg, wdata_next;
   logic                  pend_reg, pend_next;
   logic                  busy_reg;
   logic                  cmd_ready_reg;
   logic                  tx_start;
   logic                  tx_capture;
   logic                  tx_done;
   logic [FRAME_BITS-1:0] tx_word;

   // Command acceptance, frame sequencing and gap timing
   always_comb begin
      state_next = state_reg;
      write_next = write_reg;
      wdata_next = wdata_reg;
      pend_next  = pend_reg;
      tx_start   = 1'b0;
      tx_capture = 1'b0;
      tx_word    = make_frame(OP_WR_ADDR, host.cmd_addr);
      case (state_reg)
         SEQ_IDLE: begin
            if (host.cmd_valid && cmd_ready_reg) begin
               // Address goes straight into the serializer; only op and wdata are kept here
               write_next = host.cmd_write;
               wdata_next = host.cmd_wdata;
               pend_next  = 1'b1;
               tx_start   = 1'b1;
               tx_word    = make_frame(host.cmd_write ? OP_WR_ADDR : OP_RD_ADDR, host.cmd_addr);
               state_next = SEQ_FRAME;
            end
         end
         SEQ_FRAME: begin
            if (tx_done) state_next = SEQ_GAP;
         end
         SEQ_GAP: begin
            if (gcnt_reg == GAP_LAST) begin
               if (pend_reg) begin
                  pend_next  = 1'b0;
                  tx_start   = 1'b1;
                  tx_capture = !write_reg;
                  tx_word    = make_frame(write_reg ? OP_WR_DATA : OP_RD_DATA,
                                          write_reg ? wdata_reg : {DATA_BITS{1'b0}});
                  state_next = SEQ_FRAME;
               end else begin
                  state_next = SEQ_IDLE;
               end
            end
         end
         default: state_next = SEQ_IDLE;
      endcase

      if (state_next != state_reg)
         gcnt_next = '0;
      else if (gcnt_reg == GAP_LAST)
         gcnt_next = gcnt_reg;
      else
         gcnt_next = gcnt_reg + GAP_W'(1);
   end

   // Sequencer state plus registered busy/ready derived from the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= SEQ_IDLE;
         gcnt_reg      <= '0;
         write_reg     <= 1'b0;
         wdata_reg     <= '0;
         pend_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         cmd_ready_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         gcnt_reg      <= gcnt_next;
         write_reg     <= write_next;
         wdata_reg     <= wdata_next;
         pend_reg      <= pend_next;
         busy_reg      <= (state_next != SEQ_IDLE);
         cmd_ready_reg <= (state_next == SEQ_IDLE);
      end
   end

   spi_ram_master_ctrl_frame_tx #(
      .RD_LAT (RD_LAT)
   ) u_frame_tx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tx_start),
      .word     (tx_word),
      .capture  (tx_capture),
      .miso     (miso),
      .done     (tx_done),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .rd_data  (host.rd_data),
      .rd_valid (host.rd_valid)
   );

   assign host.cmd_ready = cmd_ready_reg;
   assign host.busy      = busy_reg;

endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Directed bench for spi_ram_master_ctrl: instance A uses RD_LAT=3/GAP_CYC=2 with a
// frame-decoding slave model, instance B uses RD_LAT=0/GAP_CYC=1 with a cycle-timed MISO pattern.
module tb_spi_ram_master_ctrl;
   import spi_ram_master_ctrl_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_ram_master_ctrl_if host_a ();
   spi_ram_master_ctrl_if host_b ();
   logic ss_n_a, mosi_a, miso_a;
   logic ss_n_b, mosi_b, miso_b;

   spi_ram_master_ctrl #(.RD_LAT(3), .GAP_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .host(host_a), .ss_n(ss_n_a), .mosi(mosi_a), .miso(miso_a));

   spi_ram_master_ctrl #(.RD_LAT(0), .GAP_CYC(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .host(host_b), .ss_n(ss_n_b), .mosi(mosi_b), .miso(miso_b));

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Slave model for A: decodes each complete frame, replies to read-data frames after RD_LAT
   logic [9:0] frame_q[$];
   logic       route_q[$];
   logic [7:0] slave_reply = 8'h00;
   int         sel_bad = 0;
   initial begin : slave_a
      logic [9:0] word;
      logic       route;
      int         n;
      miso_a = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && ss_n_a === 1'b0) begin
            if (mosi_a !== 1'b0) sel_bad++;
            word = '0; route = 1'b0; n = 0;
            while (n < 11) begin
               @(negedge clk);
               if (rst_n !== 1'b1 || ss_n_a !== 1'b0) break;
               if (n == 0) route = mosi_a;
               else        word  = {word[8:0], mosi_a};
               n++;
            end
            if (n == 11) begin
               frame_q.push_back(word);
               route_q.push_back(route);
               if (word[9:8] == OP_RD_DATA) begin
                  repeat (4) @(negedge clk);
                  for (int i = 7; i >= 0; i--) begin
                     miso_a = slave_reply[i];
                     @(negedge clk);
                  end
                  miso_a = 1'b0;
               end
            end
         end
      end
   end

   // Length of the most recent completed ss_n low period on A
   int last_low = 0;
   initial begin : low_mon
      int run;
      run = 0;
      forever begin
         @(negedge clk);
         if (ss_n_a === 1'b0) run++;
         else begin
            if (run != 0) last_low = run;
            run = 0;
         end
      end
   end

   // Wait (bounded) for A to go idle, counting cycles from the current one and rd_valid pulses
   task automatic wait_idle_a(output int cycles, output int pulses, output int pulse_at);
      cycles = 0; pulses = 0; pulse_at = -1;
      while (host_a.busy === 1'b1 && cycles < 200) begin
         if (host_a.rd_valid === 1'b1) begin
            pulses++;
            pulse_at = cycles;
         end
         @(negedge clk);
         cycles++;
      end
   endtask

   // Issue one command on A, then scramble the command fields while it runs
   task automatic run_cmd_a(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            output int cycles, output int pulses, output int pulse_at);
      @(negedge clk);
      host_a.cmd_valid = 1'b1;
      host_a.cmd_write = wr;
      host_a.cmd_addr  = addr;
      host_a.cmd_wdata = wdata;
      @(negedge clk);
      host_a.cmd_valid = 1'b0;
      host_a.cmd_write = ~wr;
      host_a.cmd_addr  = ~addr;
      host_a.cmd_wdata = ~wdata;
      wait_idle_a(cycles, pulses, pulse_at);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int   cyc, pul, pat, acc_at, ready_bad;
      logic s11, s12, s13;
      int   rv_at, idle_at;
      logic [7:0] sh_b;

      host_a.cmd_valid = 1'b0; host_a.cmd_write = 1'b0; host_a.cmd_addr = '0; host_a.cmd_wdata = '0;
      host_b.cmd_valid = 1'b0; host_b.cmd_write = 1'b0; host_b.cmd_addr = '0; host_b.cmd_wdata = '0;
      miso_b = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_ss_n",      32'(ss_n_a), 32'h1);
      check_val("rst_mosi",      32'(mosi_a), 32'h0);
      check_val("rst_rd_data",   32'(host_a.rd_data), 32'h0);
      check_val("rst_rd_valid",  32'(host_a.rd_valid), 32'h0);
      check_val("rst_busy",      32'(host_a.busy), 32'h0);
      check_val("rst_cmd_ready", 32'(host_a.cmd_ready), 32'h1);
      rst_n = 1'b1;

      // Write 0x3C <- 0xA5
      slave_reply = 8'hB6;
      run_cmd_a(1'b1, 8'h3C, 8'hA5, cyc, pul, pat);
      check_val("wr_cycles",      32'(cyc), 32'd28);
      check_val("wr_frame_addr",  32'(frame_q[0]), 32'h03C);
      check_val("wr_frame_data",  32'(frame_q[1]), 32'h1A5);
      check_val("wr_route",       32'(route_q[0]), 32'h0);
      check_val("wr_low_len",     32'(last_low), 32'd12);
      check_val("wr_no_rd_valid", 32'(pul), 32'd0);
      check_val("wr_ready_after", 32'(host_a.cmd_ready), 32'h1);

      // Read 0x3C, slave replies 0xB6
      run_cmd_a(1'b0, 8'h3C, 8'h00, cyc, pul, pat);
      check_val("rd_cycles",     32'(cyc), 32'd39);
      check_val("rd_frame_addr", 32'(frame_q[2]), 32'h23C);
      check_val("rd_frame_data", 32'(frame_q[3]), 32'h300);
      check_val("rd_route",      32'(route_q[3]), 32'h1);
      check_val("rd_data",       32'(host_a.rd_data), 32'hB6);
      check_val("rd_pulses",     32'(pul), 32'd1);
      check_val("rd_pulse_at",   32'(pat), 32'd37);
      check_val("rd_low_len",    32'(last_low), 32'd23);

      // Back-to-back: write 0x11<-0x5A held, then read 0x22 held
      slave_reply = 8'h3D;
      @(negedge clk);
      host_a.cmd_valid = 1'b1; host_a.cmd_write = 1'b1;
      host_a.cmd_addr = 8'h11; host_a.cmd_wdata = 8'h5A;
      @(negedge clk);
      host_a.cmd_write = 1'b0; host_a.cmd_addr = 8'h22; host_a.cmd_wdata = 8'hEE;
      acc_at = -1; ready_bad = 0; cyc = 0;
      while (cyc < 100 && acc_at < 0) begin
         if (host_a.busy === 1'b1 && host_a.cmd_ready !== 1'b0) ready_bad++;
         if (host_a.cmd_ready === 1'b1) acc_at = cyc;
         @(negedge clk);
         cyc++;
      end
      host_a.cmd_valid = 1'b0;
      wait_idle_a(cyc, pul, pat);
      check_val("b2b_accept_at",  32'(acc_at), 32'd28);
      check_val("b2b_ready_busy", 32'(ready_bad), 32'd0);
      check_val("b2b_rd_cycles",  32'(cyc), 32'd39);
      check_val("b2b_frame_4",    32'(frame_q[4]), 32'h011);
      check_val("b2b_frame_5",    32'(frame_q[5]), 32'h15A);
      check_val("b2b_frame_6",    32'(frame_q[6]), 32'h222);
      check_val("b2b_frame_7",    32'(frame_q[7]), 32'h300);
      check_val("b2b_rd_data",    32'(host_a.rd_data), 32'h3D);

      // Reset at SHIFT bit 5 of the first frame of a write
      @(negedge clk);
      host_a.cmd_valid = 1'b1; host_a.cmd_write = 1'b1;
      host_a.cmd_addr = 8'h3C; host_a.cmd_wdata = 8'hA5;
      @(negedge clk);
      host_a.cmd_valid = 1'b0;
      repeat (7) @(negedge clk);
      check_val("mid_ss_n_low", 32'(ss_n_a), 32'h0);
      check_val("mid_mosi_bit", 32'(mosi_a), 32'h1);
      rst_n = 1'b0;
      #1;
      check_val("arst_ss_n",      32'(ss_n_a), 32'h1);
      check_val("arst_mosi",      32'(mosi_a), 32'h0);
      check_val("arst_busy",      32'(host_a.busy), 32'h0);
      check_val("arst_cmd_ready", 32'(host_a.cmd_ready), 32'h1);
      check_val("arst_rd_data",   32'(host_a.rd_data), 32'h0);
      check_val("arst_rd_valid",  32'(host_a.rd_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("arst_frames_dropped", 32'(frame_q.size()), 32'd8);
      slave_reply = 8'hC3;
      run_cmd_a(1'b0, 8'h5A, 8'h00, cyc, pul, pat);
      check_val("post_rst_cycles",  32'(cyc), 32'd39);
      check_val("post_rst_frame_a", 32'(frame_q[8]), 32'h25A);
      check_val("post_rst_frame_d", 32'(frame_q[9]), 32'h300);
      check_val("post_rst_rd_data", 32'(host_a.rd_data), 32'hC3);
      check_val("sel_mosi_zero",    32'(sel_bad), 32'd0);

      // Instance B: GAP_CYC=1, RD_LAT=0 read with MISO pattern 0x96
      @(negedge clk);
      host_b.cmd_valid = 1'b1; host_b.cmd_write = 1'b0; host_b.cmd_addr = 8'h81;
      @(negedge clk);
      host_b.cmd_valid = 1'b0;
      sh_b = 8'h96; s11 = 1'bx; s12 = 1'bx; s13 = 1'bx; rv_at = -1; idle_at = -1;
      for (int n = 0; n < 60; n++) begin
         if (n >= 25 && n <= 32) begin
            miso_b = sh_b[7];
            sh_b   = {sh_b[6:0], 1'b0};
         end else begin
            miso_b = 1'b0;
         end
         if (n == 11) s11 = ss_n_b;
         if (n == 12) s12 = ss_n_b;
         if (n == 13) s13 = ss_n_b;
         if (host_b.rd_valid === 1'b1 && rv_at < 0) rv_at = n;
         if (host_b.busy !== 1'b1 && idle_at < 0) idle_at = n;
         @(negedge clk);
      end
      check_val("b_ss_n_last_low", 32'(s11), 32'h0);
      check_val("b_ss_n_gap",      32'(s12), 32'h1);
      check_val("b_ss_n_next_sel", 32'(s13), 32'h0);
      check_val("b_rd_valid_at",   32'(rv_at), 32'd33);
      check_val("b_rd_idle_at",    32'(idle_at), 32'd34);
      check_val("b_rd_data",       32'(host_b.rd_data), 32'h96);

      // Instance B write: 2*(12+1) cycles
      @(negedge clk);
      host_b.cmd_valid = 1'b1; host_b.cmd_write = 1'b1; host_b.cmd_addr = 8'h42; host_b.cmd_wdata = 8'h24;
      @(negedge clk);
      host_b.cmd_valid = 1'b0;
      cyc = 0;
      while (host_b.busy === 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check_val("b_wr_cycles", 32'(cyc), 32'd26);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
